// File: rtl/aes_inv_cipher_ctrl.sv
// ---------------------------------------------------------------------------
// aes_inv_cipher_ctrl
//
// Iterative AES-128 inverse cipher. It executes one decryption round per
// clock around a 128-bit state register. Round keys come from an external
// synchronous key store, which is addressed in descending order 10..0.
// Start is accepted at cycle T and done pulses at T+13.
//
// Ports
//   clk      in   1    system clock, rising edge
//   rst      in   1    synchronous active-high reset
//   start    in   1    start request, sampled only in IDLE
//   ct_in    in   128  ciphertext, captured on the accepted start cycle
//   rk_addr  out  4    registered round-key index to the key store
//   rk_data  in   128  round key, valid the cycle after rk_addr presents it
//   busy     out  1    high while a block is in flight (FETCH..FINAL)
//   done     out  1    one-cycle pulse, pt_out valid from this cycle
//   pt_out   out  128  plaintext, holds until the next done
//
// Byte order: bits [127:120] are byte 0 (FIPS-197 column-major).
// ---------------------------------------------------------------------------
module aes_inv_cipher_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] ct_in,
    output logic [3:0]   rk_addr,
    input  logic [127:0] rk_data,
    output logic         busy,
    output logic         done,
    output logic [127:0] pt_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_INIT  = 3'd2,
        S_ROUND = 3'd3,
        S_FINAL = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    // Inverse S-box, row 0 in the MSBs: entry b sits at bits [(255-b)*8 +: 8].
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] b);
        logic [10:0] base;
        base = {~b, 3'b000};  // (255 - b) * 8
        return INV_SBOX[base +: 8];
    endfunction

    // Byte (4c+r) takes the byte from column (c-r) mod 4 of the same row.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[(15 - (4 * c + r)) * 8 +: 8] = s[(15 - (4 * ((c + 4 - r) % 4) + r)) * 8 +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int i = 0; i < 16; i++) begin
            o[i * 8 +: 8] = inv_sub_byte(s[i * 8 +: 8]);
        end
        return o;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column times the inverse MixColumns matrix {0e,0b,0d,09} circulant.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        for (int j = 0; j < 4; j++) begin
            a[j]  = col[(3 - j) * 8 +: 8];
            x2    = xtime(a[j]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[j] = x8 ^ a[j];
            mb[j] = x8 ^ x2 ^ a[j];
            md[j] = x8 ^ x4 ^ a[j];
            me[j] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            o[(3 - c) * 32 +: 32] = inv_mix_col(s[(3 - c) * 32 +: 32]);
        end
        return o;
    endfunction

    state_e       state_q, state_d;
    logic [127:0] data_q, data_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [3:0]   rk_addr_q, rk_addr_d;
    logic [127:0] pt_q, pt_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [127:0] ark_s;
    logic [127:0] imc_s;

    // Shared round datapath; ark_s is also the final-round result.
    always_comb begin
        ark_s = inv_sub_bytes(inv_shift_rows(data_q)) ^ rk_data;
        imc_s = inv_mix_columns(ark_s);
    end

    // Next-state, datapath and key-address sequencing.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        rnd_d     = rnd_q;
        rk_addr_d = rk_addr_q;
        pt_d      = pt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    data_d    = ct_in;
                    rk_addr_d = 4'd10;
                    state_d   = S_FETCH;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_FETCH: begin
                rk_addr_d = 4'd9;
                state_d   = S_INIT;
            end
            S_INIT: begin
                data_d    = data_q ^ rk_data;
                rk_addr_d = 4'd8;
                rnd_d     = 4'd9;
                state_d   = S_ROUND;
            end
            S_ROUND: begin
                data_d = imc_s;
                rnd_d  = rnd_q - 4'd1;
                // The key store runs two indices ahead of the round in use.
                if (rnd_q >= 4'd2) begin
                    rk_addr_d = rnd_q - 4'd2;
                end else begin
                    rk_addr_d = 4'd0;
                end
                if (rnd_q == 4'd1) begin
                    state_d = S_FINAL;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_FINAL: begin
                pt_d    = ark_s;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_FETCH) || (state_d == S_INIT) ||
                 (state_d == S_ROUND) || (state_d == S_FINAL);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            data_q    <= 128'h0;
            rnd_q     <= 4'd0;
            rk_addr_q <= 4'd0;
            pt_q      <= 128'h0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            rnd_q     <= rnd_d;
            rk_addr_q <= rk_addr_d;
            pt_q      <= pt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rk_addr = rk_addr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pt_out  = pt_q;

endmodule
